dcpu16_mbus: RTL and testbench

- Bus arbiter between the dcpu16_cpu fetch port (fs_*) and data port (ab_*), and a single-port memory or peripheral slave (wb_*).
- Sits directly downstream of the CPU and upstream of the memory.
- Replaces the per-port stb/ack loopback: serialises both masters onto one stb/ack slave interface and generates each master's ack and return data.

---
 rtl/dcpu16_mbus.sv | 176 +++++++++++++++++
 tb/tb_dcpu16_mbus.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu16_mbus.sv
// dcpu16_mbus: arbiter that serialises the dcpu16 fetch port (fs_*) and data
// port (ab_*) onto a single stb/ack slave interface (wb_*).
// Optional feature macro: DCPU16_MBUS_TIMEOUT_EN. When it is defined, a
// transaction that gets no slave ack within TMO cycles is terminated with
// all-ones read data.
module dcpu16_mbus #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] fs_adr,
    input  logic [DW-1:0] fs_dto,
    input  logic          fs_stb,
    input  logic          fs_wre,
    output logic [DW-1:0] fs_dti,
    output logic          fs_ack,
    input  logic [AW-1:0] ab_adr,
    input  logic [DW-1:0] ab_dto,
    input  logic          ab_stb,
    input  logic          ab_wre,
    output logic [DW-1:0] ab_dti,
    output logic          ab_ack,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_stb_o,
    output logic          wb_wre_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GFS  = 2'd1,
        GAB  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          lst, lst_n;
    logic [AW-1:0] adr_n;
    logic [DW-1:0] dat_n;
    logic          stb_n, wre_n;
    logic          fs_ack_n, ab_ack_n;
    logic [DW-1:0] fs_dti_n, ab_dti_n;
    logic          fs_req, ab_req;
    logic          tmo_hit;
    logic          done;
    logic          take;
    logic [DW-1:0] rdata;

    // A master is masked during its own ack cycle so a strobe held through
    // the ack does not start a second slave transaction.
    assign fs_req = fs_stb & ~fs_ack;
    assign ab_req = ab_stb & ~ab_ack;

`ifdef DCPU16_MBUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    logic [7:0] cnt;
    logic       grant;

    assign grant   = (state == IDLE) && (fs_req || ab_req);
    assign tmo_hit = (state != IDLE) && (cnt == TMO_LAST);

    // Cycle counter for the active transaction: cleared on grant, counts
    // every granted cycle that passes without a slave ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (grant) begin
            cnt <= 8'd0;
        end else if ((state != IDLE) && !wb_ack_i) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    // Timeout disabled: never fires; TMO is referenced only so the parameter
    // remains a live part of the interface in this build.
    assign tmo_hit = 1'b0 & (TMO != 0);
`endif

    // A transaction ends on a slave ack, or on a timeout when no ack arrives
    // on the same edge; a real ack always returns the real read data.
    assign done  = wb_ack_i | tmo_hit;
    assign rdata = wb_ack_i ? wb_dat_i : {DW{1'b1}};
    assign take  = wb_ack_i ? ~wb_wre_o : 1'b1;

    // Next-state and next-output logic: grant in IDLE, complete in GFS/GAB.
    always_comb begin
        state_n  = state;
        lst_n    = lst;
        adr_n    = wb_adr_o;
        dat_n    = wb_dat_o;
        stb_n    = wb_stb_o;
        wre_n    = wb_wre_o;
        fs_ack_n = 1'b0;
        ab_ack_n = 1'b0;
        fs_dti_n = fs_dti;
        ab_dti_n = ab_dti;
        case (state)
            IDLE: begin
                if (ab_req && (!fs_req || !lst)) begin
                    adr_n   = ab_adr;
                    dat_n   = ab_dto;
                    wre_n   = ab_wre;
                    stb_n   = 1'b1;
                    lst_n   = 1'b1;
                    state_n = GAB;
                end else if (fs_req) begin
                    adr_n   = fs_adr;
                    dat_n   = fs_dto;
                    wre_n   = fs_wre;
                    stb_n   = 1'b1;
                    lst_n   = 1'b0;
                    state_n = GFS;
                end
            end
            GFS: begin
                if (done) begin
                    stb_n    = 1'b0;
                    wre_n    = 1'b0;
                    fs_ack_n = 1'b1;
                    if (take) begin
                        fs_dti_n = rdata;
                    end
                    state_n  = IDLE;
                end
            end
            GAB: begin
                if (done) begin
                    stb_n    = 1'b0;
                    wre_n    = 1'b0;
                    ab_ack_n = 1'b1;
                    if (take) begin
                        ab_dti_n = rdata;
                    end
                    state_n  = IDLE;
                end
            end
            default: begin
                stb_n   = 1'b0;
                wre_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lst      <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_stb_o <= 1'b0;
            wb_wre_o <= 1'b0;
            fs_ack   <= 1'b0;
            ab_ack   <= 1'b0;
            fs_dti   <= '0;
            ab_dti   <= '0;
        end else begin
            state    <= state_n;
            lst      <= lst_n;
            wb_adr_o <= adr_n;
            wb_dat_o <= dat_n;
            wb_stb_o <= stb_n;
            wb_wre_o <= wre_n;
            fs_ack   <= fs_ack_n;
            ab_ack   <= ab_ack_n;
            fs_dti   <= fs_dti_n;
            ab_dti   <= ab_dti_n;
        end
    end

endmodule

// File: tb/tb_dcpu16_mbus.sv
// tb_dcpu16_mbus: per-cycle vector table for grant/ack/arbitration behaviour,
// followed by hand-written sequences against a small registered-ack slave
// model (latency, back-to-back fetches, reset mid-transaction, timeout).
module tb_dcpu16_mbus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fs_adr, fs_dto, fs_dti;
    logic        fs_stb, fs_wre, fs_ack;
    logic [15:0] ab_adr, ab_dto, ab_dti;
    logic        ab_stb, ab_wre, ab_ack;
    logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_stb_o, wb_wre_o, wb_ack_i;

    logic        slave_en;
    logic        v_ack;
    logic [15:0] v_dat;
    logic        m_ack = 1'b0;
    logic [15:0] m_dat = 16'h0;
    logic [15:0] mem [0:255];
    int          slave_txns = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        fs_stb, fs_wre;
        logic [15:0] fs_adr, fs_dto;
        logic        ab_stb, ab_wre;
        logic [15:0] ab_adr, ab_dto;
        logic        ack;
        logic [15:0] dat;
        logic        e_stb, e_wre;
        logic [15:0] e_adr, e_dat;
        logic        e_fsack, e_aback;
        logic [15:0] e_fsdti, e_abdti;
    } vec_t;

    vec_t vecs[$];

    dcpu16_mbus #(.AW(16), .DW(16), .TMO(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .fs_adr   (fs_adr),
        .fs_dto   (fs_dto),
        .fs_stb   (fs_stb),
        .fs_wre   (fs_wre),
        .fs_dti   (fs_dti),
        .fs_ack   (fs_ack),
        .ab_adr   (ab_adr),
        .ab_dto   (ab_dto),
        .ab_stb   (ab_stb),
        .ab_wre   (ab_wre),
        .ab_dti   (ab_dti),
        .ab_ack   (ab_ack),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_stb_o (wb_stb_o),
        .wb_wre_o (wb_wre_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    always #5 clk = ~clk;

    assign wb_ack_i = slave_en ? m_ack : v_ack;
    assign wb_dat_i = slave_en ? m_dat : v_dat;

    // Slave model: acks one cycle after seeing stb, one ack per strobe.
    always @(posedge clk) begin
        if (rst || !slave_en) begin
            m_ack <= 1'b0;
        end else if (wb_stb_o && !m_ack) begin
            m_ack      <= 1'b1;
            slave_txns <= slave_txns + 1;
            if (wb_wre_o) mem[wb_adr_o[7:0]] <= wb_dat_o;
            else          m_dat <= mem[wb_adr_o[7:0]];
        end else begin
            m_ack <= 1'b0;
        end
    end

    task automatic addVec(input logic r, input logic fst, input logic fwr, input logic [15:0] fa, input logic [15:0] fd,
                          input logic ast, input logic awr, input logic [15:0] aa, input logic [15:0] ad,
                          input logic ak, input logic [15:0] dt,
                          input logic es, input logic ew, input logic [15:0] ea, input logic [15:0] ed,
                          input logic ef, input logic eb, input logic [15:0] efd, input logic [15:0] ebd);
        vec_t v;
        v.rst = r; v.fs_stb = fst; v.fs_wre = fwr; v.fs_adr = fa; v.fs_dto = fd;
        v.ab_stb = ast; v.ab_wre = awr; v.ab_adr = aa; v.ab_dto = ad;
        v.ack = ak; v.dat = dt;
        v.e_stb = es; v.e_wre = ew; v.e_adr = ea; v.e_dat = ed;
        v.e_fsack = ef; v.e_aback = eb; v.e_fsdti = efd; v.e_abdti = ebd;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst    = v.rst;
        fs_stb = v.fs_stb; fs_wre = v.fs_wre; fs_adr = v.fs_adr; fs_dto = v.fs_dto;
        ab_stb = v.ab_stb; ab_wre = v.ab_wre; ab_adr = v.ab_adr; ab_dto = v.ab_dto;
        v_ack  = v.ack;    v_dat  = v.dat;
    endtask

    task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        fs_stb = 1'b0; fs_wre = 1'b0; fs_adr = 16'h0; fs_dto = 16'h0;
        ab_stb = 1'b0; ab_wre = 1'b0; ab_adr = 16'h0; ab_dto = 16'h0;
        v_ack  = 1'b0; v_dat  = 16'h0;
    endtask

    // Returns the number of edges until the selected ack is seen, or -1.
    task automatic waitAck(input bit use_ab, input int budget, output int n);
        n = 0;
        while (1) begin
            tick();
            n++;
            if (use_ab ? ab_ack : fs_ack) return;
            if (n >= budget) begin
                n = -1;
                return;
            end
        end
    endtask

    function automatic logic [67:0] outs();
        return {wb_stb_o, wb_wre_o, wb_adr_o, wb_dat_o, fs_ack, ab_ack, fs_dti, ab_dti};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int acks;
        int cyc;
        int t0;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        slave_en = 1'b0;
        rst      = 1'b1;
        idleInputs();

        //     rst fs:stb wre adr dto      ab:stb wre adr dto      ack dat      exp: stb wre adr dat fsack aback fsdti abdti
        addVec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
        addVec(0, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 0,16'h0000, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000);
        addVec(0, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 0,16'h0000, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000);
        addVec(0, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 1,16'h7C01, 0,0,16'h0010,16'hBEEF, 1,0,16'h7C01,16'h0000);
        addVec(0, 1,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0010,16'hBEEF, 0,0,16'h7C01,16'h0000);
        addVec(0, 0,0,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0010,16'hBEEF, 0,0,16'h7C01,16'h0000);
        addVec(0, 0,0,16'h0000,16'h0000, 1,1,16'h8000,16'h1234, 0,16'h0000, 1,1,16'h8000,16'h1234, 0,0,16'h7C01,16'h0000);
        addVec(0, 0,0,16'h0000,16'h0000, 1,1,16'h8000,16'h1234, 1,16'hDEAD, 0,0,16'h8000,16'h1234, 0,1,16'h7C01,16'h0000);
        addVec(0, 0,0,16'h0000,16'h0000, 0,0,16'h8000,16'h1234, 0,16'h0000, 0,0,16'h8000,16'h1234, 0,0,16'h7C01,16'h0000);
        addVec(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0030,16'h5555, 0,0,16'h0000,16'h0000);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h1111, 0,0,16'h0030,16'h5555, 0,1,16'h0000,16'h1111);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0020,16'hAAAA, 0,0,16'h0000,16'h1111);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h2222, 0,0,16'h0020,16'hAAAA, 1,0,16'h2222,16'h1111);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0030,16'h5555, 0,0,16'h2222,16'h1111);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h3333, 0,0,16'h0030,16'h5555, 0,1,16'h2222,16'h3333);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0020,16'hAAAA, 0,0,16'h2222,16'h3333);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h4444, 0,0,16'h0020,16'hAAAA, 1,0,16'h4444,16'h3333);
        addVec(0, 0,0,16'h0020,16'hAAAA, 0,0,16'h0030,16'h5555, 0,16'h0000, 0,0,16'h0020,16'hAAAA, 0,0,16'h4444,16'h3333);
        addVec(0, 0,0,16'h0020,16'hAAAA, 0,0,16'h0030,16'h5555, 1,16'h5555, 0,0,16'h0020,16'hAAAA, 0,0,16'h4444,16'h3333);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0030,16'h5555, 0,0,16'h4444,16'h3333);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h6666, 0,0,16'h0030,16'h5555, 0,1,16'h4444,16'h6666);
        addVec(0, 0,0,16'h0020,16'hAAAA, 0,0,16'h0030,16'h5555, 0,16'h0000, 0,0,16'h0030,16'h5555, 0,0,16'h4444,16'h6666);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 0,16'h0000, 1,0,16'h0020,16'hAAAA, 0,0,16'h4444,16'h6666);
        addVec(0, 1,0,16'h0020,16'hAAAA, 1,0,16'h0030,16'h5555, 1,16'h7777, 0,0,16'h0020,16'hAAAA, 1,0,16'h7777,16'h6666);
        addVec(0, 0,0,16'h0020,16'hAAAA, 0,0,16'h0030,16'h5555, 0,16'h0000, 0,0,16'h0020,16'hAAAA, 0,0,16'h7777,16'h6666);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), outs(),
                        {vecs[i].e_stb, vecs[i].e_wre, vecs[i].e_adr, vecs[i].e_dat,
                         vecs[i].e_fsack, vecs[i].e_aback, vecs[i].e_fsdti, vecs[i].e_abdti});
        end

        // Slave-model sequences start from a clean reset.
        idleInputs();
        mem[8'h10] = 16'h7C01;
        mem[8'h30] = 16'h3030;
        mem[8'h40] = 16'h4242;
        slave_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Fetch read: stb one cycle after request, ack two cycles later.
        fs_stb = 1'b1; fs_adr = 16'h0010; fs_wre = 1'b0;
        tick();
        checkOutput("fetch_grant", {wb_stb_o, wb_adr_o}, {1'b1, 16'h0010});
        tick();
        checkOutput("fetch_wait", {wb_stb_o, fs_ack}, 2'b10);
        tick();
        checkOutput("fetch_ack", {fs_ack, ab_ack, fs_dti}, {1'b1, 1'b0, 16'h7C01});
        fs_stb = 1'b0;
        tick();
        checkOutput("fetch_pulse", {fs_ack, ab_ack, wb_stb_o}, 3'b000);

        // Data write lands in slave memory and leaves ab_dti alone.
        ab_stb = 1'b1; ab_wre = 1'b1; ab_adr = 16'h8000; ab_dto = 16'h1234;
        tick();
        checkOutput("write_grant", {wb_stb_o, wb_wre_o, wb_adr_o, wb_dat_o}, {1'b1, 1'b1, 16'h8000, 16'h1234});
        waitAck(1'b1, 10, n);
        checkOutput("write_latency", n, 2);
        checkOutput("write_dti", ab_dti, 16'h0000);
        checkOutput("write_mem", mem[8'h00], 16'h1234);
        ab_stb = 1'b0; ab_wre = 1'b0;
        tick();

        // Ten back-to-back fetches with stb held high through every ack.
        t0 = slave_txns;
        acks = 0;
        cyc = 0;
        fs_stb = 1'b1; fs_adr = 16'h0040;
        while (acks < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (fs_ack) acks++;
        end
        fs_stb = 1'b0;
        tick(); tick(); tick();
        checkOutput("b2b_acks", acks, 10);
        checkOutput("b2b_txns", slave_txns - t0, 10);
        checkOutput("b2b_dti", fs_dti, 16'h4242);

        // Reset while the slave ack is pending: no ack, everything cleared.
        fs_stb = 1'b1; fs_adr = 16'h0010;
        tick();
        tick();
        checkOutput("rst_pending", {wb_stb_o, wb_ack_i}, 2'b11);
        rst = 1'b1; fs_stb = 1'b0;
        tick();
        checkOutput("rst_outputs", outs(), 68'h0);
        rst = 1'b0;
        tick(); tick();
        checkOutput("rst_quiet", {fs_ack, ab_ack, wb_stb_o, fs_dti}, 19'h0);
        ab_stb = 1'b1; ab_wre = 1'b0; ab_adr = 16'h0030;
        waitAck(1'b1, 20, n);
        checkOutput("rst_next_latency", n, 3);
        checkOutput("rst_next_dti", ab_dti, 16'h3030);
        ab_stb = 1'b0;
        tick();

        // Silent slave: timeout terminates the fetch, or it waits forever.
        slave_en = 1'b0; v_ack = 1'b0; v_dat = 16'h0;
        tick();
        fs_stb = 1'b1; fs_adr = 16'h0050;
        tick();
        checkOutput("tmo_grant", wb_stb_o, 1'b1);
`ifdef DCPU16_MBUS_TIMEOUT_EN
        waitAck(1'b0, 100, n);
        checkOutput("tmo_latency", n, 16);
        checkOutput("tmo_dti", fs_dti, 16'hFFFF);
        fs_stb = 1'b0;
        tick();
        checkOutput("tmo_idle", {wb_stb_o, fs_ack}, 2'b00);
`else
        waitAck(1'b0, 1000, n);
        checkOutput("no_tmo_ack", n, -1);
        checkOutput("no_tmo_stb", wb_stb_o, 1'b1);
        fs_stb = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("no_tmo_reset", wb_stb_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
